// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and decode helpers for the ysyx_24100005 load/store unit.
// Sizes are log2(bytes); illegal funct3 codes collapse to a full-width unsigned access.
package ysyx_24100005_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int LOAD_UNSIGNED = 2;

  function automatic logic size_illegal(input logic [2:0] funct3, input logic wen,
                                        input logic is64);
    logic wide_bad;
    wide_bad = !is64 && (funct3[1:0] == SZ_D);
    if (wen) return funct3[LOAD_UNSIGNED] | wide_bad;
    return (funct3 == 3'b111) | wide_bad;
  endfunction

  function automatic logic [1:0] eff_size(input logic [2:0] funct3, input logic wen,
                                          input logic is64);
    if (size_illegal(funct3, wen, is64)) return is64 ? SZ_D : SZ_W;
    return funct3[1:0];
  endfunction

  function automatic logic eff_unsigned(input logic [2:0] funct3, input logic wen,
                                        input logic is64);
    return size_illegal(funct3, wen, is64) | (!wen & funct3[LOAD_UNSIGNED]);
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational lane steering: byte-enable mask and shifted store data on the way out,
// shifted and sign/zero-extended load data on the way back.
module ysyx_24100005_lsu_align #(
  parameter int XLEN = 32,
  localparam int NL = XLEN / 8,
  localparam int OB = $clog2(NL)
) (
  input  logic [OB-1:0]   off_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NL-1:0]   wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [OB:0]     nbytes;
  logic [NL-1:0]   base;
  logic [NL-1:0]   top_lane;
  logic [NL-1:0]   msb;
  logic [XLEN-1:0] raw;
  logic            sign;

  assign nbytes = (OB+1)'(1) << size_i;
  assign raw    = rdata_i >> {off_i, 3'b000};
  // The sign bit is the MSB of the highest byte lane that belongs to the access.
  assign sign   = ~uns_i & (|(msb & top_lane));

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      assign base[gi]            = (OB+1)'(gi) < nbytes;
      assign top_lane[gi]        = (OB+1)'(gi + 1) == nbytes;
      assign msb[gi]             = raw[8*gi+7];
      assign rdata_o[8*gi +: 8]  = base[gi] ? raw[8*gi +: 8] : {8{sign}};
    end
  endgenerate

  assign wmask_o = base << off_i;
  assign wdata_o = wdata_i << {off_i, 3'b000};

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle LSU: IDLE -> REQ -> RESP -> DONE with valid/ready on EXU, memory and WBU sides.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned/illegal-size accesses without touching memory.
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  localparam int   NL   = XLEN / 8;
  localparam int   OB   = $clog2(NL);
  localparam logic IS64 = (XLEN == 64);

  lsu_state_e      state_q;
  logic            req_valid_q;
  logic            wen_q;
  logic            out_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [OB-1:0]   off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [4:0]      rd_q;

  logic [1:0]      in_size;
  logic            in_uns;
  logic [NL-1:0]   wmask_al;
  logic [XLEN-1:0] wdata_al;
  logic [XLEN-1:0] rdata_al;

  assign in_size = eff_size(in_funct3, in_wen, IS64);
  assign in_uns  = eff_unsigned(in_funct3, in_wen, IS64);

`ifdef LSU_MISALIGN_TRAP_EN
  logic          err_q;
  logic          in_trap;
  logic [OB-1:0] align_m;
  assign align_m = OB'((4'd1 << in_size) - 4'd1);
  assign in_trap = size_illegal(in_funct3, in_wen, IS64) | (|(in_addr[OB-1:0] & align_m));
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .rdata_i (mem_resp_rdata),
    .wmask_o (wmask_al),
    .wdata_o (wdata_al),
    .rdata_o (rdata_al)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_q        <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            wen_q   <= in_wen;
            addr_q  <= {in_addr[ADDR_W-1:OB], {OB{1'b0}}};
            off_q   <= in_addr[OB-1:0];
            size_q  <= in_size;
            uns_q   <= in_uns;
            wdata_q <= in_wdata;
            rd_q    <= in_rd;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= in_trap;
            if (in_trap) begin
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
`else
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          // Stores also wait for a response but report zero data.
          if (mem_resp_valid) begin
            if (!wen_q) rdata_q <= rdata_al;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE) && !rst;
  assign mem_req_valid = req_valid_q;
  assign mem_req_wen   = req_valid_q & wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wmask = (req_valid_q & wen_q) ? wmask_al : '0;
  assign mem_req_wdata = (req_valid_q & wen_q) ? wdata_al : '0;
  assign out_valid     = out_valid_q;
  assign out_rdata     = rdata_q;
  assign out_rd        = rd_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench for ysyx_24100005_lsu (XLEN=32): vector table plus stall/backpressure/reset/misalign sequences.
// Checks the trap behaviour when compiled with LSU_MISALIGN_TRAP_EN, issued behaviour otherwise.
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wen         (in_wen),
    .in_funct3      (in_funct3),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_rd         (out_rd),
    .out_err        (out_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rresp;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_wen    = wen;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wdata;
    in_rd     = rd;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    accept(v.wen, v.f3, v.addr, v.wdata, v.rd);
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, {v.addr[31:2], 2'b00});
    chk("req_wen", mem_req_wen, v.wen);
    chk("req_wmask", mem_req_wmask, v.e_mask);
    chk("req_wdata", mem_req_wdata, v.e_wdata);
    chk("in_ready_busy", in_ready, 0);
    chk("out_valid_early1", out_valid, 0);
    step();
    chk("req_valid_drop", mem_req_valid, 0);
    chk("out_valid_early2", out_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = v.rresp;
    step();
    mem_resp_valid = 1'b0;
    chk("out_valid", out_valid, 1);
    chk("out_rdata", out_rdata, v.e_rdata);
    chk("out_rd", out_rd, v.rd);
    chk("out_err", out_err, 0);
    step();
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    $display("txn %0d wen=%0b f3=%0d addr=%h wmask=%b wdata=%h rdata=%h rd=%0d",
             idx, v.wen, v.f3, v.addr, mem_req_wmask, v.wdata, out_rdata, v.rd);
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic trap_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd);
    accept(wen, f3, addr, 32'hA5A5_A5A5, rd);
    chk("trap_no_req", mem_req_valid, 0);
    chk("trap_out_valid", out_valid, 1);
    chk("trap_out_err", out_err, 1);
    chk("trap_out_rdata", out_rdata, 0);
    chk("trap_out_rd", out_rd, rd);
    step();
    chk("trap_out_clear", out_valid, 0);
    chk("trap_in_ready", in_ready, 1);
    $display("txn trap wen=%0b f3=%0d addr=%h rd=%0d", wen, f3, addr, rd);
  endtask
`endif

  initial begin
    vec_t v;
    //         wen   f3      addr          wdata         rd     rresp         mask     wdata_exp     rdata_exp
    vecs[0] = '{1'b0, 3'b000, 32'h8000_0003, 32'h0,        5'd1,  32'h80AA_BBCC, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1] = '{1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 5'd2, 32'h5555_5555, 4'b1100, 32'hABCD_0000, 32'h0};
    vecs[2] = '{1'b0, 3'b101, 32'h8000_0010, 32'h0,        5'd3,  32'h0000_F00F, 4'b0000, 32'h0,        32'h0000_F00F};
    vecs[3] = '{1'b0, 3'b001, 32'h8000_0006, 32'h0,        5'd4,  32'h8001_1234, 4'b0000, 32'h0,        32'hFFFF_8001};
    vecs[4] = '{1'b0, 3'b100, 32'h8000_0001, 32'h0,        5'd5,  32'h1234_5678, 4'b0000, 32'h0,        32'h0000_0056};
    vecs[5] = '{1'b0, 3'b010, 32'h8000_0008, 32'h0,        5'd6,  32'hDEAD_BEEF, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 5'd7, 32'h0,        4'b0010, 32'h0000_A500, 32'h0};
    vecs[7] = '{1'b1, 3'b010, 32'h8000_000C, 32'hCAFE_F00D, 5'd8, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b1, 3'b000, 32'h8000_0003, 32'h0000_0077, 5'd9, 32'h0,        4'b1000, 32'h7700_0000, 32'h0};
    vecs[9] = '{1'b0, 3'b000, 32'h8000_0000, 32'h0,        5'd10, 32'h0000_007F, 4'b0000, 32'h0,        32'h0000_007F};

    rst = 1'b1;
    in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'b0; in_addr = '0; in_wdata = '0; in_rd = '0;
    out_ready = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wmask", mem_req_wmask, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    // mem_req_ready held low: request must sit unchanged.
    mem_req_ready = 1'b0;
    accept(1'b0, 3'b101, 32'h8000_0012, 32'h0, 5'd11);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", mem_req_valid, 1);
      chk("stall_req_addr", mem_req_addr, 32'h8000_0010);
      chk("stall_req_wen", mem_req_wen, 0);
      chk("stall_out_valid", out_valid, 0);
      step();
    end
    mem_req_ready = 1'b1;
    chk("stall_req_valid_last", mem_req_valid, 1);
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hF00F_0000;
    step();
    mem_resp_valid = 1'b0;
    chk("stall_out_rdata", out_rdata, 32'h0000_F00F);
    chk("stall_out_rd", out_rd, 5'd11);
    step();
    $display("txn stall lhu addr=80000012 rdata=0000f00f rd=11");

    // WBU backpressure: result must be held.
    out_ready = 1'b0;
    accept(1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd12);
    step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1357_9BDF;
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_rdata", out_rdata, 32'h1357_9BDF);
      chk("bp_out_rd", out_rd, 5'd12);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    $display("txn backpressure lw addr=80000004 rdata=13579bdf rd=12");

    // Reset while waiting for the response; the late response must be dropped.
    accept(1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd13);
    step();
    rst = 1'b1;
    #1;
    chk("abort_in_ready_rst", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_req_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_0BAD;
    step();
    mem_resp_valid = 1'b0;
    chk("abort_no_out_valid", out_valid, 0);
    chk("abort_idle", in_ready, 1);
    step();
    chk("abort_no_out_valid2", out_valid, 0);
    chk("abort_out_rdata", out_rdata, 0);
    $display("txn reset-abort lw addr=80000020 rd=13");
    run_txn(vecs[5], 10);

`ifdef LSU_MISALIGN_TRAP_EN
    trap_txn(1'b0, 3'b010, 32'h8000_0002, 5'd14);
    trap_txn(1'b0, 3'b011, 32'h8000_0000, 5'd15);
    trap_txn(1'b1, 3'b100, 32'h8000_0000, 5'd16);
    trap_txn(1'b1, 3'b001, 32'h8000_0001, 5'd17);
`else
    //  misaligned LW: shifted down, zero-filled
    v = '{1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd14, 32'h8765_4321, 4'b0000, 32'h0, 32'h0000_8765};
    run_txn(v, 11);
    // illegal load size: full-width unsigned
    v = '{1'b0, 3'b011, 32'h8000_0001, 32'h0, 5'd15, 32'hFF00_0000, 4'b0000, 32'h0, 32'h00FF_0000};
    run_txn(v, 12);
    // illegal store size: full-width store
    v = '{1'b1, 3'b100, 32'h8000_0000, 32'h1111_2222, 5'd16, 32'h0, 4'b1111, 32'h1111_2222, 32'h0};
    run_txn(v, 13);
    // misaligned SH crossing the word: upper byte truncated
    v = '{1'b1, 3'b001, 32'h8000_0003, 32'h0000_BEEF, 5'd17, 32'h0, 4'b1000, 32'hEF00_0000, 32'h0};
    run_txn(v, 14);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
